// File: rtl/csr_regfile_pkg.sv
// Shared constants for the CSR register file: CSR addresses, field
// positions, exception codes, packed layouts of the privilege registers,
// and the masked-write helper used by the write path.
package csr_regfile_pkg;

  localparam int CSR_NUM_WIDTH = 14;

  localparam logic [CSR_NUM_WIDTH-1:0] CSR_CRMD   = 14'h0000;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_PRMD   = 14'h0001;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_ECFG   = 14'h0004;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_ESTAT  = 14'h0005;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_ERA    = 14'h0006;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_BADV   = 14'h0007;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_EENTRY = 14'h000C;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE0  = 14'h0030;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE1  = 14'h0031;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE2  = 14'h0032;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_SAVE3  = 14'h0033;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID    = 14'h0040;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG   = 14'h0041;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL   = 14'h0042;
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR  = 14'h0044;

  // ESTAT.IS / ECFG.LIE bit positions
  localparam int IS_HW_LSB = 2;
  localparam int IS_HW_MSB = 9;
  localparam int IS_RSVD   = 10;
  localparam int IS_TIMER  = 11;
  localparam int IS_IPI    = 12;

  // LIE bit 10 is hardwired to zero
  localparam logic [12:0] LIE_WR_MASK = 13'h1BFF;

  localparam int EENTRY_VA_LSB = 6;

  localparam logic [5:0] ECODE_ADE    = 6'h08;
  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  // Field order matches the register bit order, so a cast to 32 bits is
  // directly the read value.
  typedef struct packed {
    logic       da;
    logic       ie;
    logic [1:0] plv;
  } crmd_t;

  typedef struct packed {
    logic       pie;
    logic [1:0] pplv;
  } prmd_t;

  localparam crmd_t CRMD_RESET = '{da: 1'b1, ie: 1'b0, plv: 2'd0};

  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Writeback-stage CSR / exception interface.
//   master: pipeline side (drives access, exception and interrupt inputs)
//   slave : CSR register file (returns read data, privilege, int, redirects)
interface csr_regfile_if
  import csr_regfile_pkg::*;
#(
  parameter int CSR_NUM_W = CSR_NUM_WIDTH
);
  logic                 csr_re;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [31:0]          csr_rvalue;
  logic                 csr_we;
  logic [31:0]          csr_wmask;
  logic [31:0]          csr_wvalue;
  logic                 wb_ex;
  logic [5:0]           wb_ecode;
  logic [8:0]           wb_esubcode;
  logic [31:0]          wb_pc;
  logic [31:0]          wb_vaddr;
  logic                 ertn_flush;
  logic [7:0]           hw_int_in;
  logic                 ipi_int_in;
  logic [1:0]           csr_plv;
  logic                 has_int;
  logic [31:0]          ex_entry;
  logic [31:0]          era_entry;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    input  csr_rvalue, csr_plv, has_int, ex_entry, era_entry
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           hw_int_in, ipi_int_in,
    output csr_rvalue, csr_plv, has_int, ex_entry, era_entry
  );
endinterface

// File: rtl/csr_regfile_timer.sv
// Constant timer: holds TCFG and the TVAL down-counter, and flags the cycle
// on which the timer interrupt must be raised.
//   clk, reset        : clock, synchronous active-high reset
//   tcfg_we_i         : software write to TCFG this edge
//   tcfg_wdata_i      : already-masked new TCFG value
//   tcfg_o            : TCFG read value {InitVal, Periodic, En}
//   tval_o            : current TVAL
//   timer_int_set_o   : set ESTAT.IS[11] on this edge
module csr_timer
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_we_i,
  input  logic [TIMER_W-1:0] tcfg_wdata_i,
  output logic [TIMER_W-1:0] tcfg_o,
  output logic [TIMER_W-1:0] tval_o,
  output logic               timer_int_set_o
);

  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic [TIMER_W-3:0] initval_q, initval_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    en_d            = en_q;
    periodic_d      = periodic_q;
    initval_d       = initval_q;
    tval_d          = tval_q;
    timer_int_set_o = 1'b0;

    if (tcfg_we_i) begin
      // A TCFG write reloads the counter and suppresses any fire this edge.
      en_d       = tcfg_wdata_i[0];
      periodic_d = tcfg_wdata_i[1];
      initval_d  = tcfg_wdata_i[TIMER_W-1:2];
      tval_d     = {tcfg_wdata_i[TIMER_W-1:2], 2'b00};
    end else if (en_q) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMER_W'(1);
      end else begin
        timer_int_set_o = 1'b1;
        if (periodic_q) begin
          tval_d = {initval_q, 2'b00};
        end else begin
          // One-shot: park at all-ones and disarm so it fires only once.
          tval_d = '1;
          en_d   = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      initval_q  <= '0;
      tval_q     <= '0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      initval_q  <= initval_d;
      tval_q     <= tval_d;
    end
  end

  assign tcfg_o = {initval_q, periodic_q, en_q};
  assign tval_o = tval_q;

endmodule

// File: rtl/csr_regfile.sv
// CSR register file, responder side of the writeback CSR/exception port.
// Combinational reads, masked writes, exception/ERTN context handling,
// interrupt sampling and the constant timer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : csr_regfile_if.slave (access, exception, interrupt lines,
//                read data, csr_plv, has_int, ex_entry, era_entry)
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  csr_regfile_if.slave  bus
);

  crmd_t       crmd_q, crmd_d;
  prmd_t       prmd_q, prmd_d;
  logic [12:0] ecfg_lie_q, ecfg_lie_d;
  logic [12:0] estat_is_q, estat_is_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [25:0] eentry_q, eentry_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d;

  logic [TIMER_W-1:0] tcfg, tval;
  logic               timer_int_set;
  logic               sw_we, ticlr_clr;
  logic [31:0]        rvalue, wr_data;

  // The read path is always live, so the read enable carries no function.
  logic unused_csr_re;
  assign unused_csr_re = bus.csr_re;

  always_comb begin
    rvalue = '0;
    case (bus.csr_num)
      CSR_CRMD:   rvalue = 32'(crmd_q);
      CSR_PRMD:   rvalue = 32'(prmd_q);
      CSR_ECFG:   rvalue = 32'(ecfg_lie_q);
      CSR_ESTAT:  rvalue = {1'b0, esubcode_q, ecode_q, 3'b000, estat_is_q};
      CSR_ERA:    rvalue = era_q;
      CSR_BADV:   rvalue = badv_q;
      CSR_EENTRY: rvalue = {eentry_q, 6'b0};
      CSR_SAVE0:  rvalue = save_q[0];
      CSR_SAVE1:  rvalue = save_q[1];
      CSR_SAVE2:  rvalue = save_q[2];
      CSR_SAVE3:  rvalue = save_q[3];
      CSR_TID:    rvalue = tid_q;
      CSR_TCFG:   rvalue = 32'(tcfg);
      CSR_TVAL:   rvalue = 32'(tval);
      default:    rvalue = '0;
    endcase
  end

  // Merging against the read value means reserved/read-only bits start at
  // their visible value; each target below keeps only its writable bits.
  assign wr_data   = masked_write(rvalue, bus.csr_wvalue, bus.csr_wmask);
  assign sw_we     = bus.csr_we & ~bus.wb_ex;
  assign ticlr_clr = sw_we && (bus.csr_num == CSR_TICLR) && wr_data[0];

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk             (clk),
    .reset           (reset),
    .tcfg_we_i       (sw_we && (bus.csr_num == CSR_TCFG)),
    .tcfg_wdata_i    (wr_data[TIMER_W-1:0]),
    .tcfg_o          (tcfg),
    .tval_o          (tval),
    .timer_int_set_o (timer_int_set)
  );

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    ecfg_lie_d = ecfg_lie_q;
    estat_is_d = estat_is_q;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    save_d     = save_q;
    tid_d      = tid_q;

    if (sw_we) begin
      case (bus.csr_num)
        CSR_CRMD:   crmd_d          = crmd_t'(wr_data[3:0]);
        CSR_PRMD:   prmd_d          = prmd_t'(wr_data[2:0]);
        CSR_ECFG:   ecfg_lie_d      = wr_data[12:0] & LIE_WR_MASK;
        CSR_ESTAT:  estat_is_d[1:0] = wr_data[1:0];
        CSR_ERA:    era_d           = wr_data;
        CSR_BADV:   badv_d          = wr_data;
        CSR_EENTRY: eentry_d        = wr_data[31:EENTRY_VA_LSB];
        CSR_SAVE0:  save_d[0]       = wr_data;
        CSR_SAVE1:  save_d[1]       = wr_data;
        CSR_SAVE2:  save_d[2]       = wr_data;
        CSR_SAVE3:  save_d[3]       = wr_data;
        CSR_TID:    tid_d           = wr_data;
        default:    ;
      endcase
    end

    estat_is_d[IS_HW_MSB:IS_HW_LSB] = bus.hw_int_in;
    estat_is_d[IS_RSVD]             = 1'b0;
    estat_is_d[IS_IPI]              = bus.ipi_int_in;
    // Software clear beats a timer fire on the same edge.
    if (ticlr_clr)          estat_is_d[IS_TIMER] = 1'b0;
    else if (timer_int_set) estat_is_d[IS_TIMER] = 1'b1;

    if (bus.wb_ex) begin
      prmd_d.pplv = crmd_q.plv;
      prmd_d.pie  = crmd_q.ie;
      crmd_d.plv  = 2'd0;
      crmd_d.ie   = 1'b0;
      era_d       = bus.wb_pc;
      ecode_d     = bus.wb_ecode;
      esubcode_d  = bus.wb_esubcode;
      if (bus.wb_ecode == ECODE_ADE)
        badv_d = (bus.wb_esubcode == ESUBCODE_ADEF) ? bus.wb_pc : bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      crmd_d.plv = prmd_q.pplv;
      crmd_d.ie  = prmd_q.pie;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q     <= CRMD_RESET;
      prmd_q     <= '0;
      ecfg_lie_q <= '0;
      estat_is_q <= '0;
      ecode_q    <= '0;
      esubcode_q <= '0;
      era_q      <= '0;
      badv_q     <= '0;
      eentry_q   <= '0;
      // NOTE: SAVE0-3 are architectural registers with a defined reset
      // value, so this small array is reset rather than left as a RAM.
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q      <= '0;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_lie_q <= ecfg_lie_d;
      estat_is_q <= estat_is_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      save_q     <= save_d;
      tid_q      <= tid_d;
    end
  end

  assign bus.csr_rvalue = rvalue;
  assign bus.csr_plv    = crmd_q.plv;
  assign bus.has_int    = crmd_q.ie & |(estat_is_q & ecfg_lie_q);
  assign bus.ex_entry   = {eentry_q, 6'b0};
  assign bus.era_entry  = era_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: a table of masked write/readback vectors
// followed by hand-written exception, timer, interrupt and reset sequences.
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  csr_regfile_if bus ();

  csr_regfile #(.TIMER_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wval;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    bus.csr_num = num;
    #1;
    v = bus.csr_rvalue;
  endtask

  task automatic check_csr(input string name, input logic [13:0] num, input logic [31:0] exp);
    logic [31:0] v;
    rd(num, v);
    check(name, v, exp);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_we     = 1'b1;
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    tick();
    bus.csr_we     = 1'b0;
  endtask

  task automatic raise_ex(input logic [5:0] ecode, input logic [8:0] esub,
                          input logic [31:0] pc, input logic [31:0] vaddr,
                          input logic ertn);
    bus.wb_ex       = 1'b1;
    bus.wb_ecode    = ecode;
    bus.wb_esubcode = esub;
    bus.wb_pc       = pc;
    bus.wb_vaddr    = vaddr;
    bus.ertn_flush  = ertn;
    tick();
    bus.wb_ex       = 1'b0;
    bus.ertn_flush  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;

    reset           = 1'b1;
    bus.csr_re      = 1'b1;
    bus.csr_num     = '0;
    bus.csr_we      = 1'b0;
    bus.csr_wmask   = '0;
    bus.csr_wvalue  = '0;
    bus.wb_ex       = 1'b0;
    bus.wb_ecode    = '0;
    bus.wb_esubcode = '0;
    bus.wb_pc       = '0;
    bus.wb_vaddr    = '0;
    bus.ertn_flush  = 1'b0;
    bus.hw_int_in   = '0;
    bus.ipi_int_in  = 1'b0;

    vecs.push_back('{"save0_full",     CSR_SAVE0,  32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678});
    vecs.push_back('{"save0_masked",   CSR_SAVE0,  32'hFFFF_0000, 32'hDEAD_BEEF, 32'hDEAD_5678});
    vecs.push_back('{"save3_masked",   CSR_SAVE3,  32'h00FF_00FF, 32'h0F0F_0F0F, 32'h000F_000F});
    vecs.push_back('{"eentry_low0",    CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8FFF, 32'h1C00_8FC0});
    vecs.push_back('{"ecfg_bit10",     CSR_ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF});
    vecs.push_back('{"ecfg_clr12",     CSR_ECFG,   32'h0000_1000, 32'h0000_0000, 32'h0000_0BFF});
    vecs.push_back('{"ecfg_zero",      CSR_ECFG,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{"estat_sw_only",  CSR_ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003});
    vecs.push_back('{"estat_clr_is0",  CSR_ESTAT,  32'h0000_0001, 32'h0000_0000, 32'h0000_0002});
    vecs.push_back('{"estat_zero",     CSR_ESTAT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{"prmd_fields",    CSR_PRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007});
    vecs.push_back('{"prmd_zero",      CSR_PRMD,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{"era_full",       CSR_ERA,    32'hFFFF_FFFF, 32'h1122_3344, 32'h1122_3344});
    vecs.push_back('{"badv_full",      CSR_BADV,   32'hFFFF_FFFF, 32'h5566_7788, 32'h5566_7788});
    vecs.push_back('{"tid_masked",     CSR_TID,    32'h0000_FFFF, 32'hA5A5_A5A5, 32'h0000_A5A5});
    vecs.push_back('{"tval_readonly",  CSR_TVAL,   32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0000});
    vecs.push_back('{"ticlr_reads0",   CSR_TICLR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"unmapped_08",    14'h0008,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"unmapped_3fff",  14'h3FFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});

    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_csr("rst_crmd", CSR_CRMD, 32'h0000_0008);
    check_csr("rst_tcfg", CSR_TCFG, 32'h0000_0000);
    check("rst_plv", 32'(bus.csr_plv), 32'd0);
    check("rst_has_int", 32'(bus.has_int), 32'd0);
    check("rst_ex_entry", bus.ex_entry, 32'h0);
    check("rst_era_entry", bus.era_entry, 32'h0);

    // Table-driven masked writes and readback
    foreach (vecs[i]) begin
      wr(vecs[i].num, vecs[i].mask, vecs[i].wval);
      check_csr(vecs[i].name, vecs[i].num, vecs[i].exp);
    end
    check("ex_entry_out", bus.ex_entry, 32'h1C00_8FC0);

    // Exception with a colliding ERA write, then ERTN
    wr(CSR_CRMD, 32'h7, 32'h7);
    check("plv3", 32'(bus.csr_plv), 32'd3);
    bus.csr_we     = 1'b1;
    bus.csr_num    = CSR_ERA;
    bus.csr_wmask  = 32'hFFFF_FFFF;
    bus.csr_wvalue = 32'hFFFF_FFFF;
    raise_ex(6'h0B, 9'd0, 32'h1C00_0100, 32'h0, 1'b0);
    bus.csr_we = 1'b0;
    check_csr("ex_prmd", CSR_PRMD, 32'h0000_0007);
    check_csr("ex_crmd", CSR_CRMD, 32'h0000_0008);
    check_csr("ex_estat", CSR_ESTAT, 32'h000B_0000);
    check_csr("ex_badv_kept", CSR_BADV, 32'h5566_7788);
    check("ex_era", bus.era_entry, 32'h1C00_0100);
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
    check("ertn_plv", 32'(bus.csr_plv), 32'd3);
    check_csr("ertn_crmd", CSR_CRMD, 32'h0000_000F);

    // ADEF together with ERTN: exception wins, BADV takes the PC
    raise_ex(ECODE_ADE, ESUBCODE_ADEF, 32'h1C00_0200, 32'hBADB_AD00, 1'b1);
    check("adef_plv", 32'(bus.csr_plv), 32'd0);
    check_csr("adef_prmd", CSR_PRMD, 32'h0000_0007);
    check_csr("adef_badv", CSR_BADV, 32'h1C00_0200);
    check_csr("adef_estat", CSR_ESTAT, 32'h0008_0000);

    // ADEM: BADV takes the faulting address
    raise_ex(ECODE_ADE, ESUBCODE_ADEM, 32'h1C00_0300, 32'hBADB_AD00, 1'b0);
    check_csr("adem_badv", CSR_BADV, 32'hBADB_AD00);
    check_csr("adem_estat", CSR_ESTAT, 32'h0048_0000);
    check_csr("adem_prmd", CSR_PRMD, 32'h0000_0000);
    check("adem_era", bus.era_entry, 32'h1C00_0300);

    // Periodic timer, InitVal 2
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
    wr(CSR_CRMD, 32'h4, 32'h4);
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    check_csr("per_tval_load", CSR_TVAL, 32'd8);
    check_csr("per_tcfg", CSR_TCFG, 32'h0000_000B);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_csr($sformatf("per_tval_%0d", k), CSR_TVAL, 32'(8 - k));
    end
    check("per_no_int_yet", 32'(bus.has_int), 32'd0);
    tick();
    check_csr("per_reload", CSR_TVAL, 32'd8);
    rd(CSR_ESTAT, v);
    check("per_is11", 32'(v[IS_TIMER]), 32'd1);
    check("per_has_int", 32'(bus.has_int), 32'd1);
    wr(CSR_TICLR, 32'h1, 32'h1);
    check("ticlr_has_int", 32'(bus.has_int), 32'd0);
    check_csr("ticlr_tval_runs", CSR_TVAL, 32'd7);
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0);
    check_csr("tcfg_off_tval", CSR_TVAL, 32'd0);

    // One-shot timer, InitVal 1
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0005);
    check_csr("os_tval_load", CSR_TVAL, 32'd4);
    repeat (4) tick();
    check_csr("os_tval_zero", CSR_TVAL, 32'd0);
    tick();
    check_csr("os_tval_park", CSR_TVAL, 32'hFFFF_FFFF);
    check_csr("os_en_clr", CSR_TCFG, 32'h0000_0004);
    rd(CSR_ESTAT, v);
    check("os_is11", 32'(v[IS_TIMER]), 32'd1);
    wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
    repeat (10) tick();
    rd(CSR_ESTAT, v);
    check("os_no_refire", 32'(v[IS_TIMER]), 32'd0);
    check_csr("os_tval_stays", CSR_TVAL, 32'hFFFF_FFFF);

    // TICLR on the same edge as a fire wins over the set
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0001);
    check_csr("prio_tval0", CSR_TVAL, 32'd0);
    wr(CSR_TICLR, 32'h1, 32'h1);
    rd(CSR_ESTAT, v);
    check("prio_is11_clear", 32'(v[IS_TIMER]), 32'd0);
    check_csr("prio_fired", CSR_TVAL, 32'hFFFF_FFFF);

    // External and IPI interrupts gated by IE and LIE
    wr(CSR_CRMD, 32'h4, 32'h0);
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_0004);
    bus.hw_int_in = 8'h01;
    tick();
    check("hw_ie0", 32'(bus.has_int), 32'd0);
    rd(CSR_ESTAT, v);
    check("hw_is", v & 32'h1FFF, 32'h0000_0004);
    wr(CSR_CRMD, 32'h4, 32'h4);
    check("hw_ie1", 32'(bus.has_int), 32'd1);
    bus.hw_int_in = 8'h00;
    #1;
    check("hw_drop_same_cycle", 32'(bus.has_int), 32'd1);
    tick();
    check("hw_drop_next", 32'(bus.has_int), 32'd0);
    wr(CSR_ECFG, 32'hFFFF_FFFF, 32'h0000_1000);
    bus.ipi_int_in = 1'b1;
    tick();
    check("ipi_has_int", 32'(bus.has_int), 32'd1);
    rd(CSR_ESTAT, v);
    check("ipi_is", v & 32'h1FFF, 32'h0000_1000);
    bus.ipi_int_in = 1'b0;

    // Reset mid-operation beats a running timer and a same-edge exception
    wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    repeat (2) tick();
    reset = 1'b1;
    raise_ex(6'h05, 9'd0, 32'h1C00_0400, 32'h0, 1'b0);
    reset = 1'b0;
    check_csr("mrst_crmd", CSR_CRMD, 32'h0000_0008);
    check_csr("mrst_prmd", CSR_PRMD, 32'h0);
    check_csr("mrst_tcfg", CSR_TCFG, 32'h0);
    check_csr("mrst_tval", CSR_TVAL, 32'h0);
    tick();
    check_csr("mrst_estat", CSR_ESTAT, 32'h0);
    check_csr("mrst_save0", CSR_SAVE0, 32'h0);
    check_csr("mrst_ecfg", CSR_ECFG, 32'h0);
    check("mrst_era", bus.era_entry, 32'h0);
    check("mrst_ex_entry", bus.ex_entry, 32'h0);
    check("mrst_has_int", 32'(bus.has_int), 32'd0);
    repeat (12) tick();
    check_csr("mrst_tval_idle", CSR_TVAL, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
